// File: rtl/uart_defs.sv
// Shared definitions for the memory-mapped UART peripheral.
// Holds the bus register addresses, the CON register bit layout,
// the common TX/RX FSM state encoding and a CON read-word helper.
package uart_defs;

    // Bus register addresses (peripheral space, addr[30]=1)
    localparam logic [31:0] UART_ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] UART_ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] UART_ADDR_CON = 32'h4000_0020;

    // CON register bit positions
    localparam int unsigned CON_TXEN   = 0;
    localparam int unsigned CON_RXEN   = 1;
    localparam int unsigned CON_TXDONE = 2;
    localparam int unsigned CON_RXRDY  = 3;
    localparam int unsigned CON_TXBUSY = 4;
    localparam int unsigned CON_OVR    = 5;
    localparam int unsigned CON_W      = 6;

    // Serial frame FSM states, shared by TX and RX
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Zero-extend the CON status bits to a bus word
    function automatic logic [31:0] con_word(input logic [CON_W-1:0] con);
        return 32'(con);
    endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// 8N1 serial receiver: 2-flop synchronizer, falling-edge start detect,
// mid-bit sampling, LSB-first shift register and a one-cycle byte_valid_o
// pulse for frames whose stop bit is high.
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   rx_i            - asynchronous serial input (idles high)
//   byte_o          - last received byte (stable while byte_valid_o is high)
//   byte_valid_o    - one-cycle pulse when a well-framed byte completes
module uart_rx_fsm
    import uart_defs::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic              sync1_q, sync2_q, prev_q;
    uart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              valid_q, valid_d;

    // Synchronizer plus one extra stage for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic; the START state waits half a bit so every later
    // sample lands on a bit centre.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    valid_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped full-duplex 8N1 UART on the CPU peripheral bus.
// Registers: TXD (transmit byte), RXD (received byte), CON (enables and
// sticky status). Level interrupt from tx_done/rx_ready gated by enables.
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   rd, wr          - bus read / write strobes
//   addr, wdata     - bus byte address and write data
//   rdata           - combinational read data (zero when not selected)
//   uart_rx         - asynchronous serial input
//   uart_tx         - serial output, idles high
//   irq             - registered level interrupt request
module uart_periph
    import uart_defs::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter logic [31:0] ADDR_TXD     = UART_ADDR_TXD,
    parameter logic [31:0] ADDR_RXD     = UART_ADDR_RXD,
    parameter logic [31:0] ADDR_CON     = UART_ADDR_CON
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // Register file state
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       tx_busy_q, tx_busy_d;
    logic       tx_done_q, tx_done_d;
    logic       rx_ready_q, rx_ready_d;
    logic       overrun_q, overrun_d;
    logic       tx_irq_en_q, tx_irq_en_d;
    logic       rx_irq_en_q, rx_irq_en_d;
    logic       irq_q, irq_d;

    // TX FSM state
    uart_state_e      tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic             uart_tx_q, uart_tx_d;

    logic             sel_txd_c, sel_rxd_c, sel_con_c;
    logic             tx_start_c, tx_end_c, con_wr_c, rxd_rd_c, con_rd_c;
    logic [CON_W-1:0] con_c;
    logic [7:0]       rx_byte_c;
    logic             rx_valid_c;
    logic             unused_wdata_c;

    assign unused_wdata_c = ^wdata[31:8];

    uart_rx_fsm #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .rx_i         (uart_rx),
        .byte_o       (rx_byte_c),
        .byte_valid_o (rx_valid_c)
    );

    // Address decode and bus strobes
    assign sel_txd_c  = (addr == ADDR_TXD);
    assign sel_rxd_c  = (addr == ADDR_RXD);
    assign sel_con_c  = (addr == ADDR_CON);
    assign tx_start_c = wr & sel_txd_c & ~tx_busy_q;
    assign con_wr_c   = wr & sel_con_c;
    assign rxd_rd_c   = rd & sel_rxd_c;
    assign con_rd_c   = rd & sel_con_c;

    // CON status word
    always_comb begin
        con_c             = '0;
        con_c[CON_TXEN]   = tx_irq_en_q;
        con_c[CON_RXEN]   = rx_irq_en_q;
        con_c[CON_TXDONE] = tx_done_q;
        con_c[CON_RXRDY]  = rx_ready_q;
        con_c[CON_TXBUSY] = tx_busy_q;
        con_c[CON_OVR]    = overrun_q;
    end

    // Combinational read mux
    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_txd_c) begin
                rdata = {24'b0, tx_data_q};
            end else if (sel_rxd_c) begin
                rdata = {24'b0, rx_data_q};
            end else if (sel_con_c) begin
                rdata = con_word(con_c);
            end
        end
    end

    // Register file update; flag sets win over read-clears in the same cycle
    always_comb begin
        tx_data_d   = tx_data_q;
        rx_data_d   = rx_data_q;
        tx_busy_d   = tx_busy_q;
        tx_done_d   = tx_done_q;
        rx_ready_d  = rx_ready_q;
        overrun_d   = overrun_q;
        tx_irq_en_d = tx_irq_en_q;
        rx_irq_en_d = rx_irq_en_q;
        irq_d       = (tx_irq_en_q & tx_done_q) | (rx_irq_en_q & rx_ready_q);

        if (con_wr_c) begin
            tx_irq_en_d = wdata[CON_TXEN];
            rx_irq_en_d = wdata[CON_RXEN];
        end

        if (tx_start_c) begin
            tx_data_d = wdata[7:0];
            tx_busy_d = 1'b1;
        end

        if (tx_end_c) begin
            tx_busy_d = 1'b0;
            tx_done_d = 1'b1;
        end else if (con_rd_c) begin
            tx_done_d = 1'b0;
        end

        if (rx_valid_c) begin
            rx_data_d  = rx_byte_c;
            rx_ready_d = 1'b1;
        end else if (rxd_rd_c) begin
            rx_ready_d = 1'b0;
        end

        // An unread byte being replaced is an overrun, unless it is being read now
        if (rx_valid_c && rx_ready_q && !rxd_rd_c) begin
            overrun_d = 1'b1;
        end else if (con_rd_c) begin
            overrun_d = 1'b0;
        end
    end

    // TX FSM next state; the line value is derived from the next state so
    // uart_tx is a clean register output aligned with the state.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_end_c   = 1'b0;
        uart_tx_d  = 1'b1;
        case (tx_state_q)
            ST_IDLE: begin
                if (tx_start_c) begin
                    tx_state_d = ST_START;
                    tx_cnt_d   = '0;
                end
            end
            ST_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_state_d = ST_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_state_d = ST_IDLE;
                    tx_cnt_d   = '0;
                    tx_end_c   = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase

        case (tx_state_d)
            ST_START: uart_tx_d = 1'b0;
            ST_DATA:  uart_tx_d = tx_data_q[tx_bit_d];
            default:  uart_tx_d = 1'b1;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data_q   <= '0;
            rx_data_q   <= '0;
            tx_busy_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            rx_ready_q  <= 1'b0;
            overrun_q   <= 1'b0;
            tx_irq_en_q <= 1'b0;
            rx_irq_en_q <= 1'b0;
            irq_q       <= 1'b0;
            tx_state_q  <= ST_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            uart_tx_q   <= 1'b1;
        end else begin
            tx_data_q   <= tx_data_d;
            rx_data_q   <= rx_data_d;
            tx_busy_q   <= tx_busy_d;
            tx_done_q   <= tx_done_d;
            rx_ready_q  <= rx_ready_d;
            overrun_q   <= overrun_d;
            tx_irq_en_q <= tx_irq_en_d;
            rx_irq_en_q <= rx_irq_en_d;
            irq_q       <= irq_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            uart_tx_q   <= uart_tx_d;
        end
    end

    assign uart_tx = uart_tx_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_uart_periph.sv
// Scoreboard bench for uart_periph at 16 clocks per bit: stimulus pushes
// expected values, a negedge monitor pops and compares the selected output.
module tb_uart_periph;

    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;
    localparam logic [31:0] A_BAD = 32'h4000_0024;

    localparam int K_NONE = 0;
    localparam int K_RD   = 1;
    localparam int K_TX   = 2;
    localparam int K_IRQ  = 3;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk, reset, rd, wr, uart_rx, uart_tx, irq;
    logic [31:0] addr, wdata, rdata;
    int          chk;
    int          total = 0;
    int          bad   = 0;
    exp_t        q[$];

    uart_periph #(.CLKS_PER_BIT(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .irq     (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compare the requested output mid-cycle against the queue head
    always @(negedge clk) begin
        if (chk != K_NONE) begin
            exp_t        e;
            logic [31:0] act;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty: got a check with no expected value");
            end else begin
                e = q.pop_front();
                case (e.kind)
                    K_TX:    act = {31'b0, uart_tx};
                    K_IRQ:   act = {31'b0, irq};
                    default: act = rdata;
                endcase
                if (act !== e.val) begin
                    bad++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        wr = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string nm);
        exp_t x;
        x.kind = K_RD; x.val = e; x.name = nm;
        q.push_back(x);
        rd = 1'b1; addr = a; chk = K_RD;
        @(posedge clk); #1;
        rd = 1'b0; addr = '0; chk = K_NONE;
    endtask

    // rdata with rd low must be zero even when the address matches
    task automatic peek_no_rd(input logic [31:0] a, input string nm);
        exp_t x;
        x.kind = K_RD; x.val = 32'h0; x.name = nm;
        q.push_back(x);
        addr = a; chk = K_RD;
        @(posedge clk); #1;
        addr = '0; chk = K_NONE;
    endtask

    task automatic check_sig(input int k, input logic v, input string nm);
        exp_t x;
        x.kind = k; x.val = {31'b0, v}; x.name = nm;
        q.push_back(x);
        chk = k;
        @(posedge clk); #1;
        chk = K_NONE;
    endtask

    // Called on the first START cycle; samples each bit centre, returns at cycle 153
    task automatic tx_frame_check(input logic [7:0] b, input string nm);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        idle(8);
        for (int k = 0; k < 10; k++) begin
            check_sig(K_TX, fr[k], $sformatf("%s_bit%0d", nm, k));
            if (k < 9) idle(15);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rx = fr[k];
            idle(16);
        end
        uart_rx = 1'b1;
    endtask

    initial begin
        logic [9:0] fa5;
        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        uart_rx = 1'b1; chk = K_NONE;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        bus_read(A_CON, 32'h0, "rst_con");
        bus_read(A_RXD, 32'h0, "rst_rxd");
        bus_read(A_TXD, 32'h0, "rst_txd");
        check_sig(K_TX, 1'b1, "rst_tx_idle");
        check_sig(K_IRQ, 1'b0, "rst_irq");

        // TX 0xA5 with busy observed at every bit and done at exactly 160 cycles
        fa5 = {1'b1, 8'hA5, 1'b0};
        bus_write(A_TXD, 32'h0000_00A5);
        idle(8);
        for (int k = 0; k < 10; k++) begin
            check_sig(K_TX, fa5[k], $sformatf("txa5_bit%0d", k));
            bus_read(A_CON, 32'h10, $sformatf("txa5_busy%0d", k));
            if (k < 9) idle(14);
        end
        idle(5);
        bus_read(A_CON, 32'h10, "txa5_busy_last");
        bus_read(A_CON, 32'h04, "txa5_done");
        bus_read(A_CON, 32'h00, "txa5_done_clr");
        bus_read(A_TXD, 32'hA5, "txa5_txd");

        // RX 0x3C
        fork
            send_rx(8'h3C, 1'b1);
            begin
                idle(140);
                bus_read(A_CON, 32'h00, "rx3c_not_yet");
            end
        join
        bus_read(A_CON, 32'h08, "rx3c_ready");
        bus_read(A_RXD, 32'h3C, "rx3c_rxd");
        bus_read(A_CON, 32'h00, "rx3c_ready_clr");

        // Overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus_read(A_CON, 32'h28, "ovr_set");
        bus_read(A_CON, 32'h08, "ovr_clr_ready_kept");
        bus_read(A_RXD, 32'h22, "ovr_rxd");
        bus_read(A_CON, 32'h00, "ovr_final");

        // Glitch then framing error: no flags, data unchanged
        uart_rx = 1'b0;
        idle(4);
        uart_rx = 1'b1;
        idle(40);
        bus_read(A_CON, 32'h00, "glitch_con");
        send_rx(8'h5A, 1'b0);
        idle(20);
        bus_read(A_CON, 32'h00, "frame_con");
        bus_read(A_RXD, 32'h22, "frame_rxd");

        // IRQ and ignored write while busy
        bus_write(A_CON, 32'h3);
        bus_write(A_TXD, 32'h55);
        fork
            tx_frame_check(8'h55, "busywr");
            begin
                idle(40);
                bus_write(A_TXD, 32'hFF);
            end
        join
        idle(7);
        check_sig(K_IRQ, 1'b0, "irq_before");
        check_sig(K_IRQ, 1'b1, "irq_rise");
        bus_read(A_CON, 32'h07, "irq_con");
        check_sig(K_IRQ, 1'b1, "irq_hold");
        check_sig(K_IRQ, 1'b0, "irq_fall");
        bus_read(A_TXD, 32'h55, "busywr_txd");

        // Reset during DATA bit 3 of 0xF0
        bus_write(A_TXD, 32'hF0);
        idle(69);
        check_sig(K_TX, 1'b0, "rstmid_bit3");
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check_sig(K_TX, 1'b1, "rstmid_tx");
        bus_read(A_CON, 32'h00, "rstmid_con");
        check_sig(K_IRQ, 1'b0, "rstmid_irq");
        bus_write(A_TXD, 32'h3C);
        tx_frame_check(8'h3C, "after_rst");
        idle(7);
        bus_read(A_CON, 32'h04, "after_rst_done");

        // Unselected reads return zero
        bus_write(A_CON, 32'h3);
        peek_no_rd(A_CON, "no_rd_zero");
        bus_read(A_BAD, 32'h0, "bad_addr");
        bus_read(A_CON, 32'h03, "con_enables");

        idle(2);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
